// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Purpose : Shared definitions for the control pipeline. It holds the
//           control-transfer, write-back source and forwarding codes, the
//           per-stage control bundle structs, the bubble constants, and the
//           helpers that narrow a bundle as it moves down the pipe.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [1:0] {
        CT_JAL    = 2'b00,
        CT_JALR   = 2'b01,
        CT_BRANCH = 2'b10,
        CT_NONE   = 2'b11
    } ct_e;

    // Write-back source selects
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       alu_src;
        logic [1:0] reg_wb_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        ct_e        ctrl_transfer;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ex_bundle_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] reg_wb_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] rd;
    } mem_bundle_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] reg_wb_src;
        logic       reg_write;
        logic [4:0] rd;
    } wb_bundle_t;

    // A bubble carries no side effects and no control transfer.
    localparam ex_bundle_t EX_BUBBLE = '{
        valid: 1'b0, alu_src: 1'b0, reg_wb_src: WB_ALU, reg_write: 1'b0,
        mem_read: 1'b0, mem_write: 1'b0, alu_op: 2'b00,
        ctrl_transfer: CT_NONE, rs1: 5'd0, rs2: 5'd0, rd: 5'd0
    };

    localparam mem_bundle_t MEM_BUBBLE = '{
        valid: 1'b0, reg_wb_src: WB_ALU, reg_write: 1'b0,
        mem_read: 1'b0, mem_write: 1'b0, rd: 5'd0
    };

    localparam wb_bundle_t WB_BUBBLE = '{
        valid: 1'b0, reg_wb_src: WB_ALU, reg_write: 1'b0, rd: 5'd0
    };

    function automatic mem_bundle_t to_mem_bundle(input ex_bundle_t b);
        mem_bundle_t m;
        m.valid      = b.valid;
        m.reg_wb_src = b.reg_wb_src;
        m.reg_write  = b.reg_write;
        m.mem_read   = b.mem_read;
        m.mem_write  = b.mem_write;
        m.rd         = b.rd;
        return m;
    endfunction

    function automatic wb_bundle_t to_wb_bundle(input mem_bundle_t b);
        wb_bundle_t w;
        w.valid      = b.valid;
        w.reg_wb_src = b.reg_wb_src;
        w.reg_write  = b.reg_write;
        w.rd         = b.rd;
        return w;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Purpose : Purely combinational hazard detection and operand forwarding.
// Ports   : ex_* / id_*      - load-use detection inputs
//           ex_redirect      - taken branch/jump resolved in EX
//           dmem_busy        - data memory not ready (freezes the pipe)
//           mem_* / wb_*     - writer info of the later stages
//           stall            - hold PC and IF/ID
//           flush_if_id      - squash IF/ID
//           bubble_ex        - load a bubble into EX on the next edge
//           fwd_a, fwd_b     - EX operand sources (00 RF, 01 MEM, 10 WB)
// ---------------------------------------------------------------------------
module hazard_unit
    import ctrl_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_redirect,
    input  logic       dmem_busy,
    input  logic       mem_valid,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    input  logic       wb_valid,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd,
    output logic       stall,
    output logic       flush_if_id,
    output logic       bubble_ex,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic load_use;
    logic mem_writes;
    logic wb_writes;

    // x0 is never a real destination, so it can never create a dependency.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign mem_writes = mem_valid && mem_reg_write && (mem_rd != 5'd0);
    assign wb_writes  = wb_valid && wb_reg_write && (wb_rd != 5'd0);

    // A memory freeze dominates everything: EX keeps its bundle, so a
    // pending redirect is simply re-presented once the memory is ready.
    // Otherwise a redirect beats load-use, since the dependent instruction
    // in ID is on the wrong path and will be squashed anyway.
    always_comb begin
        stall       = 1'b0;
        flush_if_id = 1'b0;
        bubble_ex   = 1'b0;
        if (dmem_busy) begin
            stall = 1'b1;
        end else if (ex_redirect) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (load_use) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // The younger result (MEM) is the more recent value of the register.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_writes && (mem_rd == ex_rs1)) begin
            fwd_a = FWD_MEM;
        end else if (wb_writes && (wb_rd == ex_rs1)) begin
            fwd_a = FWD_WB;
        end
        if (mem_writes && (mem_rd == ex_rs2)) begin
            fwd_b = FWD_MEM;
        end else if (wb_writes && (wb_rd == ex_rs2)) begin
            fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// ctrl_pipeline
// Purpose : Control-signal pipeline ID->EX->MEM->WB with load-use stalls,
//           redirect flushes, memory freeze and operand forwarding selects.
// Ports   : clk, rst_n          - clock, synchronous active-low reset
//           id_*                - decoded instruction control bundle
//           ex_redirect         - taken branch/jump resolved in EX
//           dmem_busy           - data memory not ready, freezes all stages
//           stall, flush_if_id  - hazard controls for PC and IF/ID
//           ex_*, mem_*, wb_*   - registered per-stage control bundles
//           fwd_a, fwd_b        - EX operand source selects
//           stall_count,
//           flush_count         - saturating event counters, present only
//                                 when CTRL_PIPELINE_PERF_EN is defined
// ---------------------------------------------------------------------------
module ctrl_pipeline
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_ALU_src,
    input  logic [1:0]  id_reg_wb_src,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic [1:0]  id_ALU_op,
    input  logic [1:0]  id_ctrl_transfer,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        ex_redirect,
    input  logic        dmem_busy,
    output logic        stall,
    output logic        flush_if_id,
    output logic        ex_valid,
    output logic        ex_ALU_src,
    output logic [1:0]  ex_reg_wb_src,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [1:0]  ex_ALU_op,
    output logic [1:0]  ex_ctrl_transfer,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic        mem_valid,
    output logic [1:0]  mem_reg_wb_src,
    output logic        mem_reg_write,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic [4:0]  mem_rd,
    output logic        wb_valid,
    output logic [1:0]  wb_reg_wb_src,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
`ifdef CTRL_PIPELINE_PERF_EN
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
`endif
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    ex_bundle_t  id_bundle;
    ex_bundle_t  ex_q;
    mem_bundle_t mem_q;
    wb_bundle_t  wb_q;
    logic        bubble_ex;

    // An invalid ID slot enters EX as a canonical bubble so that stale
    // field values can never look like a writer or a load.
    always_comb begin
        id_bundle = EX_BUBBLE;
        if (id_valid) begin
            id_bundle.valid         = 1'b1;
            id_bundle.alu_src       = id_ALU_src;
            id_bundle.reg_wb_src    = id_reg_wb_src;
            id_bundle.reg_write     = id_reg_write;
            id_bundle.mem_read      = id_mem_read;
            id_bundle.mem_write     = id_mem_write;
            id_bundle.alu_op        = id_ALU_op;
            id_bundle.ctrl_transfer = ct_e'(id_ctrl_transfer);
            id_bundle.rs1           = id_rs1;
            id_bundle.rs2           = id_rs2;
            id_bundle.rd            = id_rd;
        end
    end

    hazard_unit u_hazard (
        .ex_valid      (ex_q.valid),
        .ex_mem_read   (ex_q.mem_read),
        .ex_rs1        (ex_q.rs1),
        .ex_rs2        (ex_q.rs2),
        .ex_rd         (ex_q.rd),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_redirect   (ex_redirect),
        .dmem_busy     (dmem_busy),
        .mem_valid     (mem_q.valid),
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .wb_valid      (wb_q.valid),
        .wb_reg_write  (wb_q.reg_write),
        .wb_rd         (wb_q.rd),
        .stall         (stall),
        .flush_if_id   (flush_if_id),
        .bubble_ex     (bubble_ex),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Stage registers. Reset wins over a freeze; a freeze holds every stage.
    // A bubble into EX still lets the current EX bundle move on to MEM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= EX_BUBBLE;
            mem_q <= MEM_BUBBLE;
            wb_q  <= WB_BUBBLE;
        end else if (!dmem_busy) begin
            ex_q  <= bubble_ex ? EX_BUBBLE : id_bundle;
            mem_q <= to_mem_bundle(ex_q);
            wb_q  <= to_wb_bundle(mem_q);
        end
    end

`ifdef CTRL_PIPELINE_PERF_EN
    // Event counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush_if_id && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

    assign ex_valid         = ex_q.valid;
    assign ex_ALU_src       = ex_q.alu_src;
    assign ex_reg_wb_src    = ex_q.reg_wb_src;
    assign ex_reg_write     = ex_q.reg_write;
    assign ex_mem_read      = ex_q.mem_read;
    assign ex_mem_write     = ex_q.mem_write;
    assign ex_ALU_op        = ex_q.alu_op;
    assign ex_ctrl_transfer = ex_q.ctrl_transfer;
    assign ex_rs1           = ex_q.rs1;
    assign ex_rs2           = ex_q.rs2;
    assign ex_rd            = ex_q.rd;

    assign mem_valid        = mem_q.valid;
    assign mem_reg_wb_src   = mem_q.reg_wb_src;
    assign mem_reg_write    = mem_q.reg_write;
    assign mem_mem_read     = mem_q.mem_read;
    assign mem_mem_write    = mem_q.mem_write;
    assign mem_rd           = mem_q.rd;

    assign wb_valid         = wb_q.valid;
    assign wb_reg_wb_src    = wb_q.reg_wb_src;
    assign wb_reg_write     = wb_q.reg_write;
    assign wb_rd            = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipeline
// Purpose : Directed self-checking bench for ctrl_pipeline covering reset,
//           load-use stall, x0 immunity, forwarding priority, redirect vs
//           load-use, memory freeze with pending redirect, and reset during
//           a stall. Counter ports are checked when CTRL_PIPELINE_PERF_EN
//           is defined.
// ---------------------------------------------------------------------------
module tb_ctrl_pipeline;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ALU_src;
    logic [1:0]  id_reg_wb_src;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic [1:0]  id_ALU_op;
    logic [1:0]  id_ctrl_transfer;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        ex_redirect;
    logic        dmem_busy;
    logic        stall;
    logic        flush_if_id;
    logic        ex_valid;
    logic        ex_ALU_src;
    logic [1:0]  ex_reg_wb_src;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_ALU_op;
    logic [1:0]  ex_ctrl_transfer;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        mem_valid;
    logic [1:0]  mem_reg_wb_src;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [4:0]  mem_rd;
    logic        wb_valid;
    logic [1:0]  wb_reg_wb_src;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
`ifdef CTRL_PIPELINE_PERF_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    int numCompared;
    int numMismatched;

    localparam logic [1:0] CT_BR  = 2'b10;
    localparam logic [1:0] CT_NO  = 2'b11;

    ctrl_pipeline dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_ALU_src       (id_ALU_src),
        .id_reg_wb_src    (id_reg_wb_src),
        .id_reg_write     (id_reg_write),
        .id_mem_read      (id_mem_read),
        .id_mem_write     (id_mem_write),
        .id_ALU_op        (id_ALU_op),
        .id_ctrl_transfer (id_ctrl_transfer),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rd            (id_rd),
        .ex_redirect      (ex_redirect),
        .dmem_busy        (dmem_busy),
        .stall            (stall),
        .flush_if_id      (flush_if_id),
        .ex_valid         (ex_valid),
        .ex_ALU_src       (ex_ALU_src),
        .ex_reg_wb_src    (ex_reg_wb_src),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_ALU_op        (ex_ALU_op),
        .ex_ctrl_transfer (ex_ctrl_transfer),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_rd            (ex_rd),
        .mem_valid        (mem_valid),
        .mem_reg_wb_src   (mem_reg_wb_src),
        .mem_reg_write    (mem_reg_write),
        .mem_mem_read     (mem_mem_read),
        .mem_mem_write    (mem_mem_write),
        .mem_rd           (mem_rd),
        .wb_valid         (wb_valid),
        .wb_reg_wb_src    (wb_reg_wb_src),
        .wb_reg_write     (wb_reg_write),
        .wb_rd            (wb_rd),
`ifdef CTRL_PIPELINE_PERF_EN
        .stall_count      (stall_count),
        .flush_count      (flush_count),
`endif
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one decoded instruction into ID; loads select memory write-back
    // and the immediate operand, everything else is an ALU op
    task automatic applyStimulus(input logic v, input logic mr, input logic rw,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [1:0] ct);
        id_valid         = v;
        id_mem_read      = mr;
        id_reg_write     = rw;
        id_ALU_src       = mr;
        id_reg_wb_src    = mr ? 2'b01 : 2'b00;
        id_mem_write     = 1'b0;
        id_ALU_op        = mr ? 2'b00 : 2'b10;
        id_ctrl_transfer = ct;
        id_rs1           = rs1;
        id_rs2           = rs2;
        id_rd            = rd;
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        rst_n         = 1'b0;
        ex_redirect   = 1'b0;
        dmem_busy     = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, CT_NO);

        // Reset state
        tick();
        tick();
        checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_flush", 32'(flush_if_id), 32'd0);
        checkOutput("rst_fwd_a", 32'(fwd_a), 32'd0);
        checkOutput("rst_fwd_b", 32'(fwd_b), 32'd0);
        checkOutput("rst_ex_ct", 32'(ex_ctrl_transfer), 32'd3);
        rst_n = 1'b1;

        // Load-use: lw x5 then add x8, x5, x6
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 5'd5, CT_NO);
        tick();
        checkOutput("lu_ex_mem_read", 32'(ex_mem_read), 32'd1);
        checkOutput("lu_ex_wb_src", 32'(ex_reg_wb_src), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 5'd6, 5'd8, CT_NO);
        #1;
        checkOutput("lu_stall", 32'(stall), 32'd1);
        checkOutput("lu_flush", 32'(flush_if_id), 32'd0);
        tick();
        checkOutput("lu_ex_bubble", 32'(ex_valid), 32'd0);
        checkOutput("lu_mem_valid", 32'(mem_valid), 32'd1);
        checkOutput("lu_mem_rd", 32'(mem_rd), 32'd5);
        checkOutput("lu_stall_gone", 32'(stall), 32'd0);
        tick();
        checkOutput("lu_add_ex_valid", 32'(ex_valid), 32'd1);
        checkOutput("lu_add_ex_rs1", 32'(ex_rs1), 32'd5);
        checkOutput("lu_add_ex_rd", 32'(ex_rd), 32'd8);
        checkOutput("lu_fwd_a", 32'(fwd_a), 32'd2);
        checkOutput("lu_fwd_b", 32'(fwd_b), 32'd0);

        // x0 destination never stalls or forwards
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd2, 5'd0, 5'd0, CT_NO);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, CT_NO);
        #1;
        checkOutput("x0_stall", 32'(stall), 32'd0);
        tick();
        checkOutput("x0_ex_valid", 32'(ex_valid), 32'd1);
        checkOutput("x0_ex_rd", 32'(ex_rd), 32'd9);
        checkOutput("x0_fwd_a", 32'(fwd_a), 32'd0);
        checkOutput("x0_fwd_b", 32'(fwd_b), 32'd0);

        // Forwarding priority: two writers of x7, then a reader of x7
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd7, CT_NO);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd7, CT_NO);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 5'd7, 5'd10, CT_NO);
        tick();
        checkOutput("prio_fwd_b", 32'(fwd_b), 32'd1);
        checkOutput("prio_fwd_a", 32'(fwd_a), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 5'd11, CT_NO);
        tick();
        checkOutput("wbonly_fwd_a", 32'(fwd_a), 32'd2);
        checkOutput("wbonly_fwd_b", 32'(fwd_b), 32'd0);

        // Redirect together with a load-use condition
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 5'd12, CT_BR);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd12, 5'd0, 5'd13, CT_NO);
        ex_redirect = 1'b1;
        #1;
        checkOutput("both_flush", 32'(flush_if_id), 32'd1);
        checkOutput("both_stall", 32'(stall), 32'd0);
        tick();
        ex_redirect = 1'b0;
        checkOutput("both_ex_bubble", 32'(ex_valid), 32'd0);
        checkOutput("both_mem_valid", 32'(mem_valid), 32'd1);
        checkOutput("both_mem_rd", 32'(mem_rd), 32'd12);
        checkOutput("both_mem_read", 32'(mem_mem_read), 32'd1);

        // Freeze with a redirect pending in EX
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd4, 5'd5, 5'd0, CT_BR);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 5'd0, 5'd14, CT_NO);
        ex_redirect = 1'b1;
        dmem_busy   = 1'b1;
        #1;
        checkOutput("frz_stall", 32'(stall), 32'd1);
        checkOutput("frz_flush", 32'(flush_if_id), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("frz_ex_valid", 32'(ex_valid), 32'd1);
            checkOutput("frz_ex_rs1", 32'(ex_rs1), 32'd4);
            checkOutput("frz_ex_ct", 32'(ex_ctrl_transfer), 32'd2);
            checkOutput("frz_mem_valid", 32'(mem_valid), 32'd0);
            checkOutput("frz_wb_rd", 32'(wb_rd), 32'd12);
            checkOutput("frz_wb_valid", 32'(wb_valid), 32'd1);
            checkOutput("frz_flush_hold", 32'(flush_if_id), 32'd0);
        end
        dmem_busy = 1'b0;
        #1;
        checkOutput("rel_flush", 32'(flush_if_id), 32'd1);
        checkOutput("rel_stall", 32'(stall), 32'd0);
        tick();
        ex_redirect = 1'b0;
        checkOutput("rel_ex_bubble", 32'(ex_valid), 32'd0);
        checkOutput("rel_mem_valid", 32'(mem_valid), 32'd1);
        checkOutput("rel_wb_valid", 32'(wb_valid), 32'd0);

        // Reset asserted during a load-use stall
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 5'd5, CT_NO);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 5'd15, CT_NO);
        #1;
        checkOutput("rs_stall_before", 32'(stall), 32'd1);
        rst_n = 1'b0;
        tick();
        checkOutput("rs_ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("rs_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("rs_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rs_stall", 32'(stall), 32'd0);
`ifdef CTRL_PIPELINE_PERF_EN
        checkOutput("rs_stall_count", stall_count, 32'd0);
        checkOutput("rs_flush_count", flush_count, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        checkOutput("post_rs_ex_valid", 32'(ex_valid), 32'd1);
        checkOutput("post_rs_ex_rs1", 32'(ex_rs1), 32'd5);
        checkOutput("post_rs_ex_rd", 32'(ex_rd), 32'd15);
        checkOutput("post_rs_stall", 32'(stall), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, CT_NO);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
